// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//
// Purpose:
//   Drives an NxN output-stationary systolic multiply array. Operand rows of
//   A and B are buffered through a valid/ready load port while idle. A start
//   request clears the array, feeds the skewed edge operands, lets the
//   pipeline drain, snapshots the accumulators and then streams the result
//   matrix C out one row at a time over a valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   ld_valid   operand row write request
//   ld_ready   operand row accepted (high only while idle)
//   ld_sel     0 = A buffer, 1 = B buffer
//   ld_row     row index of the operand row
//   ld_data    operand row, element k in [k*DW +: DW]
//   start      begin a multiply (sampled only while idle)
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse after the last result row is taken
//   arr_clr    synchronous clear of all PE accumulators
//   arr_en     PE shift/accumulate enable
//   arr_a      left-edge operands, row i in [i*DW +: DW]
//   arr_b      top-edge operands, column j in [j*DW +: DW]
//   arr_c      PE accumulators, C[i][j] in [(i*N+j)*AW +: AW]
//   res_valid  result row valid
//   res_ready  result row accepted
//   res_row    index of the presented result row
//   res_data   result row, element j in [j*AW +: AW]
// ---------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int AW  = 16,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_sel,
    input  logic [$clog2(N)-1:0]  ld_row,
    input  logic [N*DW-1:0]       ld_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  arr_clr,
    output logic                  arr_en,
    output logic [N*DW-1:0]       arr_a,
    output logic [N*DW-1:0]       arr_b,
    input  logic [N*N*AW-1:0]     arr_c,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [$clog2(N)-1:0]  res_row,
    output logic [N*AW-1:0]       res_data
);

    localparam int RW       = $clog2(N);
    localparam int FEED_LEN = 3 * N - 2;
    localparam int CW       = $clog2(FEED_LEN + LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_step;
    logic [N*DW-1:0]   r_bufA [N];
    logic [N*DW-1:0]   r_bufB [N];
    logic [N*AW-1:0]   r_resBuf [N];
    logic [RW-1:0]     r_row;
    logic              r_arrClr;
    logic              r_arrEn;
    logic              r_resValid;
    logic              r_done;
    logic [N*DW-1:0]   r_arrA;
    logic [N*DW-1:0]   r_arrB;
    logic [N*AW-1:0]   r_resData;
    logic [RW-1:0]     w_nextRow;

    // Left edge at step t: row i carries A[i][t-i], so each row enters one
    // cycle later than the row above it.
    function automatic logic [N*DW-1:0] skewA(input int t);
        logic [N*DW-1:0] v;
        int k;
        v = '0;
        for (int i = 0; i < N; i++) begin
            k = t - i;
            if (k >= 0 && k < N) begin
                v[i*DW +: DW] = r_bufA[i][k*DW +: DW];
            end
        end
        return v;
    endfunction

    // Top edge at step t: column j carries B[t-j][j], skewed the same way
    // across columns so matching A/B pairs meet at PE(i,j) on step i+j+k.
    function automatic logic [N*DW-1:0] skewB(input int t);
        logic [N*DW-1:0] v;
        int k;
        v = '0;
        for (int j = 0; j < N; j++) begin
            k = t - j;
            if (k >= 0 && k < N) begin
                v[j*DW +: DW] = r_bufB[k][j*DW +: DW];
            end
        end
        return v;
    endfunction

    assign w_nextRow = r_row + 1'b1;

    // Sequencer FSM. Every array/result output is registered and is loaded
    // on the transition into the state it belongs to, so the outputs seen
    // during a cycle always describe the state held during that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_row      <= '0;
            r_arrClr   <= 1'b0;
            r_arrEn    <= 1'b0;
            r_resValid <= 1'b0;
            r_done     <= 1'b0;
            r_arrA     <= '0;
            r_arrB     <= '0;
            r_resData  <= '0;
            for (int i = 0; i < N; i++) begin
                r_bufA[i]   <= '0;
                r_bufB[i]   <= '0;
                r_resBuf[i] <= '0;
            end
        end else begin
            r_done   <= 1'b0;
            r_arrClr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // ld_ready is high in idle, so a request is a transfer;
                    // a load alongside start still lands before the first
                    // FEED step reads the buffers.
                    if (ld_valid) begin
                        if (ld_sel) begin
                            r_bufB[ld_row] <= ld_data;
                        end else begin
                            r_bufA[ld_row] <= ld_data;
                        end
                    end
                    if (start) begin
                        r_state  <= S_CLEAR;
                        r_arrClr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_FEED;
                    r_step  <= '0;
                    r_arrEn <= 1'b1;
                    r_arrA  <= skewA(0);
                    r_arrB  <= skewB(0);
                end
                S_FEED: begin
                    if (r_step == CW'(FEED_LEN - 1)) begin
                        r_step <= '0;
                        r_arrA <= '0;
                        r_arrB <= '0;
                        if (LAT > 0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_CAPTURE;
                            r_arrEn <= 1'b0;
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                        r_arrA <= skewA(int'(r_step) + 1);
                        r_arrB <= skewB(int'(r_step) + 1);
                    end
                end
                S_DRAIN: begin
                    if (r_step == CW'(LAT - 1)) begin
                        r_state <= S_CAPTURE;
                        r_arrEn <= 1'b0;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Rows of C are contiguous in arr_c, so each result row
                    // is a straight slice; row 0 is presented immediately.
                    for (int i = 0; i < N; i++) begin
                        r_resBuf[i] <= arr_c[i*N*AW +: N*AW];
                    end
                    r_resData  <= arr_c[N*AW-1:0];
                    r_row      <= '0;
                    r_resValid <= 1'b1;
                    r_state    <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (res_ready) begin
                        if (r_row == RW'(N - 1)) begin
                            r_state    <= S_IDLE;
                            r_resValid <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_row     <= w_nextRow;
                            r_resData <= r_resBuf[w_nextRow];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ld_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign arr_clr   = r_arrClr;
    assign arr_en    = r_arrEn;
    assign arr_a     = r_arrA;
    assign arr_b     = r_arrB;
    assign res_valid = r_resValid;
    assign res_row   = r_row;
    assign res_data  = r_resData;

endmodule

// File: tb/tb_matmul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Purpose:
//   Self-checking bench for matmul_sequencer. A behavioural output-stationary
//   PE grid closes the loop between arr_a/arr_b/arr_en/arr_clr and arr_c.
//   Expected results come from a plain matrix product of the loaded
//   operands, truncated to the accumulator width.
// ---------------------------------------------------------------------------
module tb_matmul_sequencer;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int LAT = 2;
    localparam int RW  = $clog2(N);

    logic              clk;
    logic              rst;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [RW-1:0]     ld_row;
    logic [N*DW-1:0]   ld_data;
    logic              start;
    logic              busy;
    logic              done;
    logic              arr_clr;
    logic              arr_en;
    logic [N*DW-1:0]   arr_a;
    logic [N*DW-1:0]   arr_b;
    logic [N*N*AW-1:0] arr_c;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_row;
    logic [N*AW-1:0]   res_data;

    matmul_sequencer #(.N(N), .DW(DW), .AW(AW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_row    (ld_row),
        .ld_data   (ld_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .arr_clr   (arr_clr),
        .arr_en    (arr_en),
        .arr_a     (arr_a),
        .arr_b     (arr_b),
        .arr_c     (arr_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_row   (res_row),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE grid: operands move right/down one PE per enabled
    // cycle, each PE accumulates the product of what it receives.
    logic signed [AW-1:0] acc  [N][N];
    logic signed [DW-1:0] aReg [N][N];
    logic signed [DW-1:0] bReg [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic signed [DW-1:0] inA;
                logic signed [DW-1:0] inB;
                if (j == 0) inA = $signed(arr_a[i*DW +: DW]);
                else        inA = aReg[i][j-1];
                if (i == 0) inB = $signed(arr_b[j*DW +: DW]);
                else        inB = bReg[i-1][j];
                if (arr_clr) begin
                    acc[i][j]  <= '0;
                    aReg[i][j] <= '0;
                    bReg[i][j] <= '0;
                end else if (arr_en) begin
                    acc[i][j]  <= acc[i][j] + inA * inB;
                    aReg[i][j] <= inA;
                    bReg[i][j] <= inB;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : gRow
        for (genvar gj = 0; gj < N; gj++) begin : gCol
            assign arr_c[(gi*N+gj)*AW +: AW] = acc[gi][gj];
        end
    end

    int nCompared   = 0;
    int nMismatched = 0;

    int                   mA   [N][N];
    int                   mB   [N][N];
    logic signed [AW-1:0] expC [N][N];
    logic signed [AW-1:0] gotC [N][N];
    int                   gotRows [$];
    int                   latency;
    int                   stallChanges;
    int                   validDrops;
    int                   overlapCount;
    logic                 doneSeen;
    logic                 doneAfter;
    logic                 busyInDone;
    logic                 validInDone;
    logic                 busyAfter;
    logic                 injLdReady;

    // Reference result: plain matrix product wrapped to the accumulator width.
    task automatic computeExpected();
        int sum;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int k = 0; k < N; k++) sum += mA[i][k] * mB[k][j];
                expC[i][j] = sum[AW-1:0];
            end
        end
    endtask

    task automatic loadRow(input logic sel, input int r);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = RW'(r);
        for (int k = 0; k < N; k++) begin
            ld_data[k*DW +: DW] = sel ? DW'(mB[r][k]) : DW'(mA[r][k]);
        end
    endtask

    task automatic loadMatrices(input bit skipLastB);
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < N; r++) begin
                if (!(s == 1 && r == N - 1 && skipLastB)) begin
                    loadRow(s[0], r);
                    @(negedge clk);
                end
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic setIdentityCase();
        int bRows [N][N] = '{'{1, 2, 3, 4}, '{9, 10, 11, 12},
                             '{17, 14, 19, 20}, '{25, 26, 27, 24}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mA[i][j] = (i == j) ? 1 : 0;
                mB[i][j] = bRows[i][j];
            end
        end
        computeExpected();
    endtask

    // Pulses start, watches the run and gathers the result rows. Only
    // records observations; the calling test decides what they must be.
    task automatic runCollect(input int readyMode, input int injectAt, input bit chain);
        int edges;
        int cyc;
        int guard;
        int r;
        bit rdy;
        bit prevStalled;
        logic [RW-1:0]   prevRow;
        logic [N*AW-1:0] prevData;
        gotRows.delete();
        stallChanges = 0;
        validDrops   = 0;
        overlapCount = 0;
        injLdReady   = 1'b1;
        latency      = -1;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b0;
        edges    = 0;
        while (!res_valid && edges < 200) begin
            if (arr_clr && arr_en) overlapCount++;
            if (edges == injectAt) begin
                start    = 1'b1;
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_row   = '0;
                ld_data  = N*DW'($urandom);
                injLdReady = ld_ready;
            end
            @(negedge clk);
            start    = 1'b0;
            ld_valid = 1'b0;
            edges++;
        end
        if (!res_valid) return;
        latency     = edges;
        cyc         = 0;
        guard       = 0;
        prevStalled = 1'b0;
        prevRow     = '0;
        prevData    = '0;
        while (gotRows.size() < N && guard < 200) begin
            if (prevStalled && (res_row !== prevRow || res_data !== prevData)) stallChanges++;
            if (!res_valid) validDrops++;
            if (arr_clr && arr_en) overlapCount++;
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            res_ready = rdy;
            if (res_valid && rdy) begin
                r = int'(res_row);
                gotRows.push_back(r);
                for (int j = 0; j < N; j++) gotC[r][j] = res_data[j*AW +: AW];
            end
            prevStalled = res_valid && !rdy;
            prevRow     = res_row;
            prevData    = res_data;
            @(negedge clk);
            cyc++;
            guard++;
        end
        res_ready   = 1'b0;
        doneSeen    = done;
        busyInDone  = busy;
        validInDone = res_valid;
        if (!chain) begin
            @(negedge clk);
            doneAfter = done;
            busyAfter = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if (ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_status: ld_ready=%b busy=%b done=%b, required 1/0/0", ld_ready, busy, done);
        end
        nCompared++;
        if (arr_clr !== 1'b0 || arr_en !== 1'b0 || arr_a !== '0 || arr_b !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_array: clr=%b en=%b a=%h b=%h, required all zero", arr_clr, arr_en, arr_a, arr_b);
        end
        nCompared++;
        if (res_valid !== 1'b0 || res_row !== '0 || res_data !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_result: valid=%b row=%0d data=%h, required all zero", res_valid, res_row, res_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        setIdentityCase();
        loadMatrices(1'b0);
        runCollect(0, -1, 1'b0);
        nCompared++;
        if (latency != 3 * N + LAT) begin
            nMismatched++;
            $display("[TB] FAIL t1_latency: got %0d edges, required %0d", latency, 3 * N + LAT);
        end
        for (int k = 0; k < N; k++) begin
            nCompared++;
            if (gotRows.size() <= k || gotRows[k] != k) begin
                nMismatched++;
                $display("[TB] FAIL t1_row_order: position %0d got %0d, required %0d", k, (gotRows.size() > k) ? gotRows[k] : -1, k);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== expC[i][j]) begin
                    nMismatched++;
                    $display("[TB] FAIL t1_c[%0d][%0d]: got %0d, required %0d", i, j, gotC[i][j], expC[i][j]);
                end
            end
        end
        nCompared++;
        if (doneSeen !== 1'b1 || doneAfter !== 1'b0 || busyInDone !== 1'b0 || validInDone !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL t1_done: done=%b next=%b busy=%b valid=%b, required 1/0/0/0", doneSeen, doneAfter, busyInDone, validInDone);
        end
        nCompared++;
        if (overlapCount != 0) begin
            nMismatched++;
            $display("[TB] FAIL t1_clr_en_overlap: got %0d cycles, required 0", overlapCount);
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mA[i][j] = -1;
                mB[i][j] = 127;
            end
        end
        loadMatrices(1'b0);
        runCollect(0, -1, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== 16'shFE04) begin
                    nMismatched++;
                    $display("[TB] FAIL t2_c[%0d][%0d]: got %h, required fe04", i, j, gotC[i][j]);
                end
            end
        end
    endtask

    task automatic test_stall();
        setIdentityCase();
        loadMatrices(1'b0);
        runCollect(1, -1, 1'b0);
        for (int k = 0; k < N; k++) begin
            nCompared++;
            if (gotRows.size() != N || gotRows[k] != k) begin
                nMismatched++;
                $display("[TB] FAIL t3_row_order: position %0d got %0d (count %0d), required %0d", k, (gotRows.size() > k) ? gotRows[k] : -1, gotRows.size(), k);
            end
        end
        nCompared++;
        if (stallChanges != 0 || validDrops != 0) begin
            nMismatched++;
            $display("[TB] FAIL t3_stall_stable: changes=%0d drops=%0d, required 0/0", stallChanges, validDrops);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== expC[i][j]) begin
                    nMismatched++;
                    $display("[TB] FAIL t3_c[%0d][%0d]: got %0d, required %0d", i, j, gotC[i][j], expC[i][j]);
                end
            end
        end
    endtask

    task automatic test_ignore_busy();
        setIdentityCase();
        loadMatrices(1'b0);
        runCollect(0, 4, 1'b0);
        nCompared++;
        if (injLdReady !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL t4_ld_ready: got %b during FEED, required 0", injLdReady);
        end
        nCompared++;
        if (latency != 3 * N + LAT || busyAfter !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL t4_no_restart: latency=%0d busy_after=%b, required %0d/0", latency, busyAfter, 3 * N + LAT);
        end
        // A second run shows whether the ignored load leaked into the buffers.
        runCollect(0, -1, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== expC[i][j]) begin
                    nMismatched++;
                    $display("[TB] FAIL t4_c[%0d][%0d]: got %0d, required %0d", i, j, gotC[i][j], expC[i][j]);
                end
            end
        end
    endtask

    task automatic test_midop_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nCompared++;
        if (busy !== 1'b0 || arr_en !== 1'b0 || arr_clr !== 1'b0 || arr_a !== '0 || arr_b !== '0
            || res_valid !== 1'b0 || ld_ready !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL t5_reset_outputs: busy=%b en=%b clr=%b a=%h b=%h valid=%b ready=%b done=%b, required idle zeros", busy, arr_en, arr_clr, arr_a, arr_b, res_valid, ld_ready, done);
        end
        rst = 1'b1;
        @(negedge clk);
        // Buffers were zeroed by reset, so a run without reloading gives C = 0.
        runCollect(0, -1, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== '0) begin
                    nMismatched++;
                    $display("[TB] FAIL t5_zero_c[%0d][%0d]: got %0d, required 0", i, j, gotC[i][j]);
                end
            end
        end
        setIdentityCase();
        loadMatrices(1'b0);
        runCollect(0, -1, 1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== expC[i][j]) begin
                    nMismatched++;
                    $display("[TB] FAIL t5_c[%0d][%0d]: got %0d, required %0d", i, j, gotC[i][j], expC[i][j]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        setIdentityCase();
        runCollect(0, -1, 1'b1);
        nCompared++;
        if (doneSeen !== 1'b1 || busyInDone !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL t6_first_done: done=%b busy=%b, required 1/0", doneSeen, busyInDone);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== expC[i][j]) begin
                    nMismatched++;
                    $display("[TB] FAIL t6_first_c[%0d][%0d]: got %0d, required %0d", i, j, gotC[i][j], expC[i][j]);
                end
            end
        end
        // Start raised in the done cycle itself.
        runCollect(0, -1, 1'b0);
        nCompared++;
        if (latency != 3 * N + LAT) begin
            nMismatched++;
            $display("[TB] FAIL t6_second_latency: got %0d edges, required %0d", latency, 3 * N + LAT);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                nCompared++;
                if (gotC[i][j] !== expC[i][j]) begin
                    nMismatched++;
                    $display("[TB] FAIL t6_second_c[%0d][%0d]: got %0d, required %0d", i, j, gotC[i][j], expC[i][j]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    mA[i][j] = int'($urandom_range(0, 255)) - 128;
                    mB[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            end
            computeExpected();
            // The last B row goes in on the same cycle as start.
            loadMatrices(1'b1);
            loadRow(1'b1, N - 1);
            runCollect(2, -1, 1'b0);
            nCompared++;
            if (latency != 3 * N + LAT || gotRows.size() != N) begin
                nMismatched++;
                $display("[TB] FAIL rand%0d_flow: latency=%0d rows=%0d, required %0d/%0d", it, latency, gotRows.size(), 3 * N + LAT, N);
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    nCompared++;
                    if (gotC[i][j] !== expC[i][j]) begin
                        nMismatched++;
                        $display("[TB] FAIL rand%0d_c[%0d][%0d]: got %0d, required %0d", it, i, j, gotC[i][j], expC[i][j]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        ld_valid  = 1'b0;
        ld_sel    = 1'b0;
        ld_row    = '0;
        ld_data   = '0;
        start     = 1'b0;
        res_ready = 1'b0;
        doneAfter = 1'b0;
        busyAfter = 1'b0;
        test_reset();
        test_identity();
        test_negative();
        test_stall();
        test_ignore_busy();
        test_midop_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
